pipeline_stage_reg: RTL

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_stage_reg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer.
// Holds up to two entries (main + skid) so that IN_READY can be decoded
// purely from registered state while still sustaining one transfer per
// cycle. FLUSH discards all held entries synchronously. When the stage
// is empty, OUT_CTRL presents BUBBLE_CTRL so downstream sees a harmless
// no-op control word.
module pipeline_stage_reg #(
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    CTRL_WIDTH  = 24,
    parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    input  logic                  FLUSH,
    output logic [1:0]            OCCUPANCY
);

    // Encoding equals the number of held entries, so OCCUPANCY is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [DATA_WIDTH-1:0]   main_data;
    logic [CTRL_WIDTH-1:0]   main_ctrl;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic [CTRL_WIDTH-1:0]   skid_ctrl;

    logic                    in_fire;
    logic                    out_fire;
    logic                    load_main_in;
    logic                    load_main_skid;
    logic                    load_skid;

    // Handshake outputs depend on registered state only.
    assign IN_READY  = (state != SKID);
    assign OUT_VALID = (state != EMPTY);
    assign OCCUPANCY = state;
    assign OUT_DATA  = main_data;
    assign OUT_CTRL  = (state == EMPTY) ? BUBBLE_CTRL : main_ctrl;

    assign in_fire   = IN_VALID  && IN_READY;
    assign out_fire  = OUT_VALID && OUT_READY;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and register-load decode.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_next   = FULL;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = SKID;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = FULL;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        // Flush wins over everything: the offered entry is dropped and any
        // entry consumed at this edge needs no further action.
        if (FLUSH) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Main and skid payload registers.
    // NOTE: payload registers are reset as well, because OUT_DATA must read
    // zero during reset rather than whatever the flops powered up with.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= IN_DATA;
                main_ctrl <= IN_CTRL;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= IN_DATA;
                skid_ctrl <= IN_CTRL;
            end
        end
    end

endmodule
